// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: fetches one word at a time over
// a req/ack memory handshake and presents it downstream over valid/ready.
module pc_fetch #(
  parameter int unsigned            WIDTH      = 16,
  parameter int unsigned            IWIDTH     = 16,
  parameter logic [WIDTH-1:0]       RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_addr,
  output logic              imem_req,
  output logic [WIDTH-1:0]  imem_addr,
  input  logic              imem_ack,
  input  logic [IWIDTH-1:0] imem_data,
  output logic              instr_valid,
  output logic [IWIDTH-1:0] instr,
  output logic [WIDTH-1:0]  instr_pc,
  input  logic              instr_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } fetchState_t;

  fetchState_t      state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pcInc;
  logic             redirect;
  logic [WIDTH-1:0] redirectAddr;

  // Wraps modulo 2^WIDTH by truncation.
  assign pcInc        = WIDTH'(pc + WIDTH'(1));
  assign redirect     = clear | load;
  assign redirectAddr = clear ? RESET_ADDR : load_addr;

  // The request address is the PC register itself, so it is stable while REQ waits.
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_ADDR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else if (redirect) begin
      // Restart/redirect flushes any pending word, including one acked this cycle.
      state       <= REQ;
      pc          <= redirectAddr;
      imem_req    <= 1'b1;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            state       <= OUT;
            instr       <= imem_data;
            instr_pc    <= pc;
            pc          <= pcInc;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        OUT: begin
          if (instr_ready) begin
            state       <= REQ;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level reference model.
module tb_pc_fetch;

  localparam int unsigned W  = 16;
  localparam int unsigned IW = 16;
  localparam logic [W-1:0] RA = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_addr = '0;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_data = '0;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [W-1:0]  instr_pc;
  logic          instr_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model: a fetch is outstanding, a word is held, or neither (just out of reset).
  logic [W-1:0]  mPc;
  logic          mReq;
  logic          mValid;
  logic [IW-1:0] mInstr;
  logic [W-1:0]  mIpc;

  pc_fetch #(.WIDTH(W), .IWIDTH(IW), .RESET_ADDR(RA)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_addr(load_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mPc = RA; mReq = 1'b0; mValid = 1'b0; mInstr = '0; mIpc = '0;
  endtask

  task automatic compareAll(input string tag);
    checkVal({tag, ":req"}, 32'(imem_req), 32'(mReq));
    checkVal({tag, ":valid"}, 32'(instr_valid), 32'(mValid));
    checkVal({tag, ":excl"}, 32'(imem_req & instr_valid), 32'(0));
    if (mReq) checkVal({tag, ":addr"}, 32'(imem_addr), 32'(mPc));
    if (mValid) begin
      checkVal({tag, ":instr"}, 32'(instr), 32'(mInstr));
      checkVal({tag, ":ipc"}, 32'(instr_pc), 32'(mIpc));
    end
  endtask

  task automatic compareReset(input string tag);
    checkVal({tag, ":req"}, 32'(imem_req), 32'(0));
    checkVal({tag, ":valid"}, 32'(instr_valid), 32'(0));
    checkVal({tag, ":addr"}, 32'(imem_addr), 32'(RA));
    checkVal({tag, ":instr"}, 32'(instr), 32'(0));
    checkVal({tag, ":ipc"}, 32'(instr_pc), 32'(0));
  endtask

  // Apply one cycle of inputs, advance the model over the edge, then compare.
  task automatic step(input logic c, input logic l, input logic [W-1:0] la,
                      input logic a, input logic [IW-1:0] d, input logic r,
                      input string tag);
    clear = c; load = l; load_addr = la; imem_ack = a; imem_data = d; instr_ready = r;
    @(posedge clk);
    if (c) begin
      mPc = RA; mValid = 1'b0; mReq = 1'b1;
    end else if (l) begin
      mPc = la; mValid = 1'b0; mReq = 1'b1;
    end else if (!mReq && !mValid) begin
      mReq = 1'b1;
    end else if (mReq) begin
      if (a) begin
        mInstr = d; mIpc = mPc; mPc = mPc + 16'd1; mValid = 1'b1; mReq = 1'b0;
      end
    end else if (r) begin
      mValid = 1'b0; mReq = 1'b1;
    end
    #1;
    compareAll(tag);
  endtask

  function automatic logic [IW-1:0] memWord();
    return mPc ^ 16'hA5A5;
  endfunction

  initial begin
    modelReset();
    #2;
    compareReset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait memory, always-ready consumer.
    step(0, 0, '0, 1, memWord(), 1, "t1_idle");
    checkVal("t1_req_c1", 32'(imem_req), 32'(1));
    step(0, 0, '0, 1, memWord(), 1, "t1_f0");
    checkVal("t1_word0", 32'(instr), 32'(16'hA5A5));
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, memWord(), 1, "t1_run");
    checkVal("t1_word2", 32'(instr), 32'(16'hA5A7));
    checkVal("t1_pc2", 32'(instr_pc), 32'(2));

    // Stalled consumer; acks arriving outside REQ must be ignored.
    step(0, 0, '0, 1, memWord(), 1, "t2_req");
    step(0, 0, '0, 1, memWord(), 0, "t2_fetch");
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 16'($urandom), 0, "t2_hold");

    // Slow memory: three wait cycles before the ack.
    step(0, 0, '0, 0, '0, 1, "t3_req");
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 16'($urandom), 0, "t3_wait");
    step(0, 0, '0, 1, memWord(), 0, "t3_ack");

    // Redirect while holding a word, then redirect colliding with an ack.
    step(0, 1, 16'h0100, 0, '0, 1, "t4_load_out");
    checkVal("t4_addr", 32'(imem_addr), 32'(16'h0100));
    step(0, 1, 16'h0200, 1, 16'hDEAD, 0, "t4_load_ack");
    checkVal("t4_addr2", 32'(imem_addr), 32'(16'h0200));

    // Clear from the top of the address space, then wrap of pc+1.
    step(0, 1, 16'hFFFF, 0, '0, 0, "t5_load");
    step(1, 0, '0, 1, 16'hBEEF, 0, "t5_clear");
    checkVal("t5_addr_clr", 32'(imem_addr), 32'(RA));
    step(0, 1, 16'hFFFF, 0, '0, 0, "t5_load2");
    step(0, 0, '0, 1, memWord(), 0, "t5_fetch");
    checkVal("t5_ipc", 32'(instr_pc), 32'(16'hFFFF));
    step(0, 0, '0, 0, '0, 1, "t5_next");
    checkVal("t5_wrap", 32'(imem_addr), 32'(0));

    // Asynchronous reset while a request is outstanding.
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    compareReset("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, '0, 1, memWord(), 1, "t6_idle");
    step(0, 0, '0, 1, memWord(), 1, "t6_f0");
    checkVal("t6_ipc", 32'(instr_pc), 32'(RA));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic c, l, a, r;
      logic [W-1:0] la;
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 19) == 0);
      a  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      la = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      step(c, l, la, a, 16'($urandom), r, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
